// File: rtl/div_unit.sv
// Multi-cycle signed divider (restoring shift-subtract, one quotient bit per cycle).
// Quotient ends in lo, remainder in hi; divide-by-zero reports div_zero instead of done.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quo starts as |a| and is shifted out into rem while quotient bits shift in.
    always_comb begin
        a_abs   = a[WIDTH-1] ? -a : a;
        b_abs   = b[WIDTH-1] ? -b : b;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            quo    <= a_abs;
                            dvs    <= b_abs;
                            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r <= a[WIDTH-1];
                            rem    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A borrow out of the top bit means the trial subtraction went negative.
                    if (trial[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                    end else begin
                        rem <= trial[WIDTH-1:0];
                    end
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= sign_q ? -quo : quo;
                    hi    <= sign_r ? -rem : rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {hi,lo} pushed to a scoreboard at start, popped at done.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests;
    int failed;
    logic [63:0] sb[$];

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MIPS DIV reference: truncating quotient, remainder follows dividend sign.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input int restart_at);
        int lat;
        int busy_cnt;
        logic dz_seen;
        logic [63:0] exp;
        lat = 0;
        dz_seen = 1'b0;
        a = av;
        b = bv;
        start = 1'b1;
        sb.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == restart_at);
            if (start) begin
                a = 32'd9;
                b = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
            if (div_zero) dz_seen = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("latency", lat, 33);
        check("busy_cycles", busy_cnt, 33);
        check("busy_at_done", busy, 1'b0);
        check("no_div_zero", dz_seen, 1'b0);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check("hi_lo", {hi, lo}, exp);
    endtask

    task automatic pulse_off();
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        do_div(32'd100, 32'd7, 0);
        pulse_off();

        // Divide by zero: one-cycle flag, results retained, stays idle.
        a = 32'd5;
        b = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dz_pulse", div_zero, 1'b1);
        check("dz_done", done, 1'b0);
        check("dz_busy", busy, 1'b0);
        check("dz_keep", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);
        check("dz_one_cycle", div_zero, 1'b0);
        check("dz_idle_busy", busy, 1'b0);

        do_div(32'hFFFF_FFF9, 32'd2, 0);
        do_div(32'd7, 32'hFFFF_FFFE, 0);
        pulse_off();

        do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        pulse_off();

        do_div(32'd100, 32'd7, 5);
        pulse_off();

        do_div(32'd0, 32'h1234_5678, 0);
        do_div(32'hFFFF_FFFF, 32'd1, 0);
        pulse_off();

        for (int k = 0; k < 3; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom | 32'h1;
            do_div(ra, rb, 0);
        end
        pulse_off();

        // Abort mid-division with an asynchronous reset.
        do_div(32'd100, 32'd7, 0);
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic done_seen;
            done_seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done) done_seen = 1'b1;
            end
            check("abort_no_done", done_seen, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_hilo", {hi, lo}, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
